// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization tree endpoints.
// The signal-pair typedef is a macro because its field widths are set by each module's parameters.
`ifndef FRACTAL_SYNC_PKG_SV
`define FRACTAL_SYNC_PKG_SV

`define FSYNC_TYPEDEF_SIG(name_t, AW, IW) \
  typedef struct packed { \
    logic [(AW)-1:0] aggr; \
    logic [(IW)-1:0] id; \
  } name_t;

package fractal_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } fsync_init_state_e;

endpackage

`endif

// File: rtl/fractal_sync_initiator.sv
// Core-side fractal sync endpoint: one barrier in flight, registered request strobe,
// one-cycle-latency done pulse on match or timeout, with sticky spurious/timeout flags.
module fractal_sync_initiator
  import fractal_sync_pkg::*;
#(
  parameter int unsigned AGGREGATE_WIDTH = 1,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bar_valid_i,
  output logic                       bar_ready_o,
  input  logic [AGGREGATE_WIDTH-1:0] bar_aggr_i,
  input  logic [ID_WIDTH-1:0]        bar_id_i,
  output logic                       done_o,
  output logic                       done_error_o,
  output logic [ID_WIDTH-1:0]        done_id_o,
  output logic                       spurious_o,
  output logic                       timeout_o,
  output logic                       req_sync_o,
  output logic [AGGREGATE_WIDTH-1:0] req_aggr_o,
  output logic [ID_WIDTH-1:0]        req_id_o,
  input  logic                       rsp_wake_i,
  input  logic                       rsp_error_i,
  input  logic [AGGREGATE_WIDTH-1:0] rsp_aggr_i,
  input  logic [ID_WIDTH-1:0]        rsp_id_i
);

  `FSYNC_TYPEDEF_SIG(fsync_sig_t, AGGREGATE_WIDTH, ID_WIDTH)

  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_cnt_too_narrow
    $error("TIMEOUT_CYCLES does not fit in CNT_WIDTH bits");
  end

  localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                   TimeoutEn  = (TIMEOUT_CYCLES != 0);

  fsync_init_state_e    state_q;
  fsync_sig_t           sig_q;
  fsync_sig_t           req_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 req_sync_q;
  logic                 done_q, done_error_q;
  logic [ID_WIDTH-1:0]  done_id_q;
  logic                 spurious_q, timeout_q;

  logic rsp_any, rsp_match, timeout_hit;

  // Responses only match while a barrier is outstanding; anything in IDLE is spurious.
  assign rsp_any     = rsp_wake_i | rsp_error_i;
  assign rsp_match   = rsp_any && (state_q != IDLE) &&
                       (rsp_id_i == sig_q.id) && (rsp_aggr_i == sig_q.aggr);
  assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign timeout_hit = TimeoutEn && (state_q == WAIT) && (cnt_q == TimeoutCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sig_q        <= '0;
      req_q        <= '0;
      cnt_q        <= '0;
      req_sync_q   <= 1'b0;
      done_q       <= 1'b0;
      done_error_q <= 1'b0;
      done_id_q    <= '0;
      spurious_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      req_sync_q <= 1'b0;
      done_q     <= 1'b0;
      if (rsp_any && !rsp_match) begin
        spurious_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bar_valid_i) begin
            sig_q   <= '{aggr: bar_aggr_i, id: bar_id_i};
            state_q <= SEND;
          end
        end
        SEND: begin
          cnt_q      <= '0;
          req_sync_q <= 1'b1;
          req_q      <= sig_q;
          if (rsp_match) begin
            done_q       <= 1'b1;
            done_error_q <= rsp_error_i;
            done_id_q    <= sig_q.id;
            state_q      <= IDLE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          // A match in the timeout cycle takes priority and completes cleanly.
          if (rsp_match) begin
            done_q       <= 1'b1;
            done_error_q <= rsp_error_i;
            done_id_q    <= sig_q.id;
            state_q      <= IDLE;
          end else if (timeout_hit) begin
            done_q       <= 1'b1;
            done_error_q <= 1'b1;
            done_id_q    <= sig_q.id;
            timeout_q    <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bar_ready_o  = (state_q == IDLE);
  assign req_sync_o   = req_sync_q;
  assign req_aggr_o   = req_q.aggr;
  assign req_id_o     = req_q.id;
  assign done_o       = done_q;
  assign done_error_o = done_error_q;
  assign done_id_o    = done_id_q;
  assign spurious_o   = spurious_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Directed bench for fractal_sync_initiator with hand-computed expectations.
module tb_fractal_sync_initiator;

  localparam int AW = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bar_valid = 1'b0;
  logic          bar_ready;
  logic [AW-1:0] bar_aggr = '0;
  logic [IW-1:0] bar_id = '0;
  logic          done, done_error;
  logic [IW-1:0] done_id;
  logic          spurious, timeout;
  logic          req_sync;
  logic [AW-1:0] req_aggr;
  logic [IW-1:0] req_id;
  logic          rsp_wake = 1'b0;
  logic          rsp_error = 1'b0;
  logic [AW-1:0] rsp_aggr = '0;
  logic [IW-1:0] rsp_id = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fractal_sync_initiator #(
    .AGGREGATE_WIDTH(AW),
    .ID_WIDTH       (IW),
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (4)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bar_valid_i (bar_valid),
    .bar_ready_o (bar_ready),
    .bar_aggr_i  (bar_aggr),
    .bar_id_i    (bar_id),
    .done_o      (done),
    .done_error_o(done_error),
    .done_id_o   (done_id),
    .spurious_o  (spurious),
    .timeout_o   (timeout),
    .req_sync_o  (req_sync),
    .req_aggr_o  (req_aggr),
    .req_id_o    (req_id),
    .rsp_wake_i  (rsp_wake),
    .rsp_error_i (rsp_error),
    .rsp_aggr_i  (rsp_aggr),
    .rsp_id_i    (rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue a barrier and follow it to the first WAIT cycle (counter = 1 afterwards).
  task automatic start_bar(input logic [AW-1:0] a, input logic [IW-1:0] i, input string tag);
    bar_valid = 1'b1;
    bar_aggr  = a;
    bar_id    = i;
    tick();
    bar_valid = 1'b0;
    check({tag, ".send_ready"}, bar_ready, 0);
    check({tag, ".send_req"},   req_sync, 0);
    check({tag, ".send_done"},  done, 0);
    tick();
    check({tag, ".req_sync"}, req_sync, 1);
    check({tag, ".req_aggr"}, req_aggr, a);
    check({tag, ".req_id"},   req_id, i);
    tick();
    check({tag, ".req_pulse"}, req_sync, 0);
  endtask

  task automatic respond(input logic w, input logic e, input logic [AW-1:0] a, input logic [IW-1:0] i);
    rsp_wake  = w;
    rsp_error = e;
    rsp_aggr  = a;
    rsp_id    = i;
    tick();
    rsp_wake  = 1'b0;
    rsp_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    // Reset with bar_valid held: nothing may be captured.
    bar_valid = 1'b1;
    bar_aggr  = 2'd1;
    tick();
    tick();
    check("rst.ready",    bar_ready, 1);
    check("rst.req",      req_sync, 0);
    check("rst.done",     done, 0);
    check("rst.done_err", done_error, 0);
    check("rst.done_id",  done_id, 0);
    check("rst.spurious", spurious, 0);
    check("rst.timeout",  timeout, 0);
    rst = 1'b0;
    bar_valid = 1'b0;
    tick();
    check("rst.no_capture", bar_ready, 1);

    // Wake completion, then back-to-back accept in the done cycle.
    start_bar(2'd1, 2'd0, "b0");
    repeat (4) tick();
    check("b0.waiting", bar_ready, 0);
    respond(1'b1, 1'b0, 2'd1, 2'd0);
    check("b0.done",     done, 1);
    check("b0.done_err", done_error, 0);
    check("b0.done_id",  done_id, 0);
    check("b0.ready",    bar_ready, 1);

    // Error completion with id=1.
    start_bar(2'd2, 2'd1, "b1");
    check("b1.prev_done_cleared", done, 0);
    respond(1'b0, 1'b1, 2'd2, 2'd1);
    check("b1.done",     done, 1);
    check("b1.done_err", done_error, 1);
    check("b1.done_id",  done_id, 1);
    check("b1.spurious", spurious, 0);

    // Mismatched id and aggr are spurious; FSM keeps waiting.
    start_bar(2'd3, 2'd1, "b2");
    respond(1'b1, 1'b0, 2'd3, 2'd0);
    check("b2.spurious", spurious, 1);
    check("b2.no_done",  done, 0);
    check("b2.waiting",  bar_ready, 0);
    respond(1'b1, 1'b0, 2'd2, 2'd1);
    check("b2.aggr_miss_no_done", done, 0);
    respond(1'b1, 1'b0, 2'd3, 2'd1);
    check("b2.done",     done, 1);
    check("b2.done_err", done_error, 0);
    check("b2.done_id",  done_id, 1);
    check("b2.sticky",   spurious, 1);

    // Timeout: counter reaches 8 after 7 more WAIT cycles, fires on the next edge.
    do_reset();
    check("b3.rst_spurious", spurious, 0);
    start_bar(2'd1, 2'd2, "b3");
    repeat (7) begin
      tick();
      check("b3.no_early_done", done, 0);
    end
    tick();
    check("b3.done",     done, 1);
    check("b3.done_err", done_error, 1);
    check("b3.done_id",  done_id, 2);
    check("b3.timeout",  timeout, 1);
    check("b3.spurious", spurious, 0);
    respond(1'b1, 1'b0, 2'd1, 2'd2);
    check("b3.late_spurious", spurious, 1);
    check("b3.late_no_done",  done, 0);

    // Match in the timeout cycle wins.
    do_reset();
    start_bar(2'd2, 2'd3, "b4");
    repeat (7) tick();
    check("b4.no_early_done", done, 0);
    respond(1'b1, 1'b0, 2'd2, 2'd3);
    check("b4.done",     done, 1);
    check("b4.done_err", done_error, 0);
    check("b4.done_id",  done_id, 3);
    check("b4.timeout",  timeout, 0);
    check("b4.spurious", spurious, 0);

    // Reset in WAIT discards the barrier; a later response is spurious.
    start_bar(2'd1, 2'd1, "b5");
    tick();
    rst       = 1'b1;
    bar_valid = 1'b1;
    bar_aggr  = 2'd2;
    tick();
    check("b5.rst_done",  done, 0);
    check("b5.rst_ready", bar_ready, 1);
    check("b5.rst_req",   req_sync, 0);
    check("b5.rst_id",    done_id, 0);
    rst       = 1'b0;
    bar_valid = 1'b0;
    tick();
    check("b5.no_capture", bar_ready, 1);
    check("b5.no_done",    done, 0);
    respond(1'b1, 1'b0, 2'd1, 2'd1);
    check("b5.spurious",     spurious, 1);
    check("b5.late_no_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
